alu_share_arbiter: RTL

- Shares one add_sub instance (32-bit add/subtract with overflow, isNotEqual and isLessThan flags) between two requesters.
- Requesters are, for example, the execute stage and the multdiv sequencer.
- Round-robin arbitration, a valid/ready request handshake, registered results, and a held response handshake.
- Sits between the requesters and the single shared add/sub datapath instantiated inside this block.

---
 rtl/alu_share_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit add/sub datapath.
// Each operation runs IDLE (grant) -> EXEC (evaluate) -> RESP (hold until consumed).

module add_sub (
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  output logic [31:0] data_result,
  output logic        overflow,
  output logic        isNotEqual,
  output logic        isLessThan
);
  logic        sub_s;
  logic [31:0] b_eff_s;
  logic [31:0] low_sum_s;
  logic [1:0]  msb_sum_s;
  logic        carry_msb_in_s;

  // Split the add so the carry into and out of bit 31 are both visible for overflow.
  assign sub_s          = (ctrl_ALUopcode == 5'b10001);
  assign b_eff_s        = sub_s ? ~data_operandB : data_operandB;
  assign low_sum_s      = {1'b0, data_operandA[30:0]} + {1'b0, b_eff_s[30:0]} + {31'd0, sub_s};
  assign carry_msb_in_s = low_sum_s[31];
  assign msb_sum_s      = {1'b0, data_operandA[31]} + {1'b0, b_eff_s[31]} + {1'b0, carry_msb_in_s};
  assign data_result    = {msb_sum_s[0], low_sum_s[30:0]};
  assign overflow       = carry_msb_in_s ^ msb_sum_s[1];
  assign isNotEqual     = (data_operandA != data_operandB);
  assign isLessThan     = data_result[31] ^ overflow;
endmodule

module alu_share_arbiter #(
  parameter bit INIT_PRIO = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic             req_sub_0,
  input  logic             req_sub_1,
  input  logic [31:0]      opA_0,
  input  logic [31:0]      opA_1,
  input  logic [31:0]      opB_0,
  input  logic [31:0]      opB_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             ne,
  output logic             lt,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic             sub_q;
  logic [31:0]      result_q;
  logic             ovf_q;
  logic             ne_q;
  logic             lt_q;
  logic             resp_valid_0_q;
  logic             resp_valid_1_q;
  logic [CNT_W-1:0] op_count_q;

  logic             grant_any_s;
  logic             grant_sel_s;
  logic             owner_resp_ready_s;
  logic [31:0]      alu_result_s;
  logic             alu_ovf_s;
  logic             alu_ne_s;
  logic             alu_lt_s;

  add_sub u_add_sub (
    .data_operandA  (opa_q),
    .data_operandB  (opb_q),
    .ctrl_ALUopcode ({4'b1000, sub_q}),
    .data_result    (alu_result_s),
    .overflow       (alu_ovf_s),
    .isNotEqual     (alu_ne_s),
    .isLessThan     (alu_lt_s)
  );

  // Winner selection: a lone requester wins outright, a tie goes to the priority holder.
  always_comb begin
    grant_any_s = 1'b0;
    grant_sel_s = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_any_s = 1'b1;
      grant_sel_s = prio_q;
    end else if (req_valid_0) begin
      grant_any_s = 1'b1;
      grant_sel_s = 1'b0;
    end else if (req_valid_1) begin
      grant_any_s = 1'b1;
      grant_sel_s = 1'b1;
    end else begin
      grant_any_s = 1'b0;
      grant_sel_s = 1'b0;
    end
  end

  assign req_ready_0        = (state_q == IDLE) && grant_any_s && !grant_sel_s;
  assign req_ready_1        = (state_q == IDLE) && grant_any_s &&  grant_sel_s;
  assign owner_resp_ready_s = owner_q ? resp_ready_1 : resp_ready_0;

  // Arbitration FSM, operand capture, result registers and completion bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      prio_q         <= INIT_PRIO;
      owner_q        <= 1'b0;
      opa_q          <= 32'd0;
      opb_q          <= 32'd0;
      sub_q          <= 1'b0;
      result_q       <= 32'd0;
      ovf_q          <= 1'b0;
      ne_q           <= 1'b0;
      lt_q           <= 1'b0;
      resp_valid_0_q <= 1'b0;
      resp_valid_1_q <= 1'b0;
      op_count_q     <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any_s) begin
            opa_q   <= grant_sel_s ? opA_1 : opA_0;
            opb_q   <= grant_sel_s ? opB_1 : opB_0;
            sub_q   <= grant_sel_s ? req_sub_1 : req_sub_0;
            owner_q <= grant_sel_s;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q       <= alu_result_s;
          ovf_q          <= alu_ovf_s;
          ne_q           <= alu_ne_s;
          lt_q           <= alu_lt_s;
          resp_valid_0_q <= ~owner_q;
          resp_valid_1_q <= owner_q;
          state_q        <= RESP;
        end
        RESP: begin
          // Priority flips only here, so a busy pair of requesters strictly alternates.
          if (owner_resp_ready_s) begin
            op_count_q     <= op_count_q + CNT_W'(1);
            prio_q         <= ~owner_q;
            resp_valid_0_q <= 1'b0;
            resp_valid_1_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          resp_valid_0_q <= 1'b0;
          resp_valid_1_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid_0 = resp_valid_0_q;
  assign resp_valid_1 = resp_valid_1_q;
  assign result       = result_q;
  assign ovf          = ovf_q;
  assign ne           = ne_q;
  assign lt           = lt_q;
  assign busy         = (state_q != IDLE);
  assign op_count     = op_count_q;

endmodule
